if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues requests to instruction memory, buffers a
// word that returns while the ID register is frozen, and handles redirects
// (including redirects that land while a request is still in flight).
module if_stage #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  valid
);

  typedef enum logic [1:0] {
    S_REQ,      // ready to issue (or issuing) a new request
    S_WAIT,     // request issued, memory has not answered yet
    S_HOLD,     // word returned while frozen, parked in pending
    S_DISCARD   // redirect arrived mid-request; drop the answer when it comes
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [WORD_WIDTH-1:0] pending_q, pending_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] instruction_q, instruction_d;
  logic                  valid_q, valid_d;

  logic                  req_int;
  logic                  deliver;
  logic [WORD_WIDTH-1:0] deliver_word;
  logic                  keep_outstanding;
  logic [WORD_WIDTH-1:0] branch_target;
  logic [WORD_WIDTH-1:0] next_pc;

  // Branch targets are word aligned: the two low address bits are cleared.
  assign branch_target = branch_addr & ~WORD_WIDTH'(3);
  assign next_pc       = fetch_pc_q + WORD_WIDTH'(4);

  // A request is on the bus when issuing in S_REQ or while one is in flight.
  always_comb begin
    unique case (state_q)
      S_REQ:     req_int = ~freeze;
      S_WAIT:    req_int = 1'b1;
      S_DISCARD: req_int = 1'b1;
      default:   req_int = 1'b0;
    endcase
  end

  // The reset term forces the request low immediately, ahead of any clock.
  assign imem_req    = req_int & ~rst;
  assign imem_addr   = fetch_pc_q;
  assign pc          = pc_q;
  assign instruction = instruction_q;
  assign valid       = valid_q;

  // A branch that arrives while a request is still unanswered must wait for
  // that answer (the address has to stay stable), so it is parked in
  // redirect_pc and the stale word is thrown away in S_DISCARD.
  assign keep_outstanding = ~imem_ready &
                            ((state_q == S_REQ && req_int) ||
                             state_q == S_WAIT || state_q == S_DISCARD);

  // Next-state, delivery and redirect decisions for the whole stage.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    pending_d     = pending_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    valid_d       = freeze ? valid_q : 1'b0;
    deliver       = 1'b0;
    deliver_word  = imem_rdata;

    unique case (state_q)
      S_REQ: begin
        if (!freeze) begin
          if (imem_ready) deliver = 1'b1;
          else            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ready) begin
          if (!freeze) begin
            deliver = 1'b1;
            state_d = S_REQ;
          end else begin
            pending_d = imem_rdata;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!freeze) begin
          deliver      = 1'b1;
          deliver_word = pending_q;
          state_d      = S_REQ;
        end
      end
      S_DISCARD: begin
        if (imem_ready) begin
          fetch_pc_d = redirect_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (deliver) begin
      pc_d          = next_pc;
      instruction_d = deliver_word;
      valid_d       = 1'b1;
      fetch_pc_d    = next_pc;
    end

    // A redirect overrides freeze and any delivery decided above.
    if (branch_taken) begin
      valid_d       = 1'b0;
      instruction_d = '0;
      pending_d     = '0;
      pc_d          = pc_q;
      if (keep_outstanding) begin
        redirect_pc_d = branch_target;
        fetch_pc_d    = fetch_pc_q;
        state_d       = S_DISCARD;
      end else begin
        fetch_pc_d = branch_target;
        state_d    = S_REQ;
      end
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      pending_q     <= '0;
      pc_q          <= '0;
      instruction_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      pending_q     <= pending_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset/wrap
// sequences, then randomized traffic against a transaction-level model.
module tb_if_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, freeze, branch_taken, imem_ready;
  logic [W-1:0] branch_addr, imem_rdata;
  logic         imem_req, valid;
  logic [W-1:0] imem_addr, pc, instruction;

  // Second instance for the address-wrap case.
  logic         w_rst, w_freeze, w_branch_taken, w_imem_ready;
  logic [W-1:0] w_branch_addr, w_imem_rdata;
  logic         w_imem_req, w_valid;
  logic [W-1:0] w_imem_addr, w_pc, w_instruction;

  int errors = 0;
  int checks = 0;

  if_stage #(.WORD_WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc),
    .instruction(instruction), .valid(valid)
  );

  if_stage #(.WORD_WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .freeze(w_freeze), .branch_taken(w_branch_taken),
    .branch_addr(w_branch_addr), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .imem_ready(w_imem_ready), .pc(w_pc),
    .instruction(w_instruction), .valid(w_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         frz;
    logic         br;
    logic [W-1:0] baddr;
    logic         rdy;
    logic [W-1:0] rdata;
    logic         e_req;
    logic [W-1:0] e_addr;
    logic         e_valid;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic frz, input logic br, input logic [W-1:0] baddr,
                     input logic rdy, input logic [W-1:0] rdata, input logic e_req,
                     input logic [W-1:0] e_addr, input logic e_valid,
                     input logic [W-1:0] e_pc, input logic [W-1:0] e_instr);
    vec_t v;
    v.frz = frz; v.br = br; v.baddr = baddr; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  logic [W-1:0] m_fetch, m_redir, m_held_word, m_pc, m_instr;
  logic         m_outstanding, m_dropping, m_held, m_valid;

  task automatic model_reset(input logic [W-1:0] start);
    m_fetch = start; m_redir = '0; m_held_word = '0; m_pc = '0; m_instr = '0;
    m_outstanding = 0; m_dropping = 0; m_held = 0; m_valid = 0;
  endtask

  function automatic logic model_req(input logic frz);
    return !m_held && (m_outstanding || !frz);
  endfunction

  task automatic model_deliver(input logic [W-1:0] word);
    m_fetch = m_fetch + 4;
    m_pc    = m_fetch;
    m_instr = word;
    m_valid = 1;
  endtask

  // One clock edge with the inputs that were on the pins before it.
  task automatic model_edge(input logic frz, input logic br, input logic [W-1:0] baddr,
                            input logic rdy, input logic [W-1:0] rdata);
    logic req;
    req = model_req(frz);
    if (br) begin
      m_valid = 0; m_instr = '0; m_held = 0;
      if (req && !rdy) begin
        m_outstanding = 1; m_dropping = 1; m_redir = {baddr[W-1:2], 2'b00};
      end else begin
        m_outstanding = 0; m_dropping = 0; m_fetch = {baddr[W-1:2], 2'b00};
      end
    end else if (req && rdy) begin
      m_outstanding = 0;
      if (m_dropping) begin
        m_dropping = 0; m_fetch = m_redir;
        if (!frz) m_valid = 0;
      end else if (!frz) begin
        model_deliver(rdata);
      end else begin
        m_held = 1; m_held_word = rdata;
      end
    end else if (req) begin
      m_outstanding = 1;
      if (!frz) m_valid = 0;
    end else if (m_held && !frz) begin
      m_held = 0;
      model_deliver(m_held_word);
    end else if (!frz) begin
      m_valid = 0;
    end
  endtask

  task automatic drive(input logic frz, input logic br, input logic [W-1:0] baddr,
                       input logic rdy, input logic [W-1:0] rdata);
    freeze = frz; branch_taken = br; branch_addr = baddr;
    imem_ready = rdy; imem_rdata = rdata;
  endtask

  initial begin
    logic         r_frz, r_br, r_rdy;
    logic [W-1:0] r_baddr, r_rdata;

    rst = 1; drive(0, 0, '0, 0, '0);
    w_rst = 1; w_freeze = 0; w_branch_taken = 0; w_branch_addr = '0;
    w_imem_ready = 1; w_imem_rdata = 32'h1234_5678;

    // Streaming, rdata = addr ^ A5A5A5A5
    add(0,0,0,1,32'hA5A5A5A5, 1,32'h0, 1,32'h4,32'hA5A5A5A5);
    add(0,0,0,1,32'hA5A5A5A1, 1,32'h4, 1,32'h8,32'hA5A5A5A1);
    add(0,0,0,1,32'hA5A5A5AD, 1,32'h8, 1,32'hC,32'hA5A5A5AD);
    // Freeze capture in S_WAIT, hold, then release
    add(0,0,0,0,32'h0,        1,32'hC, 0,32'hC,32'hA5A5A5AD);
    add(1,0,0,1,32'h11111111, 1,32'hC, 0,32'hC,32'hA5A5A5AD);
    add(1,0,0,1,32'hBAD0BAD0, 0,32'hC, 0,32'hC,32'hA5A5A5AD);
    add(0,0,0,0,32'h0,        0,32'hC, 1,32'h10,32'h11111111);
    add(0,0,0,0,32'h0,        1,32'h10,0,32'h10,32'h11111111);
    // Branch while outstanding: address stays, answer dropped
    add(0,1,32'h103,0,32'h0,  1,32'h10,0,32'h10,32'h0);
    add(0,0,0,0,32'h0,        1,32'h10,0,32'h10,32'h0);
    add(1,0,0,0,32'h0,        1,32'h10,0,32'h10,32'h0);
    add(0,0,0,1,32'hDEADBEEF, 1,32'h10,0,32'h10,32'h0);
    add(0,0,0,1,32'h22222222, 1,32'h100,1,32'h104,32'h22222222);
    // Branch + freeze with valid=1
    add(1,1,32'h2002,1,32'h33,0,32'h104,0,32'h104,32'h0);
    add(0,0,0,1,32'h44444444, 1,32'h2000,1,32'h2004,32'h44444444);
    // Branch while completing in S_REQ
    add(0,1,32'h50,1,32'h55,  1,32'h2004,0,32'h2004,32'h0);
    add(0,0,0,1,32'h66,       1,32'h50,1,32'h54,32'h66);
    // Two branches during discard: newest wins
    add(0,0,0,0,32'h0,        1,32'h54,0,32'h54,32'h66);
    add(0,1,32'h300,0,32'h0,  1,32'h54,0,32'h54,32'h0);
    add(0,1,32'h401,0,32'h0,  1,32'h54,0,32'h54,32'h0);
    add(0,0,0,1,32'h77,       1,32'h54,0,32'h54,32'h0);
    add(0,0,0,1,32'h88,       1,32'h400,1,32'h404,32'h88);
    // Branch in S_HOLD drops the parked word
    add(0,0,0,0,32'h0,        1,32'h404,0,32'h404,32'h88);
    add(1,0,0,1,32'h99,       1,32'h404,0,32'h404,32'h88);
    add(1,1,32'h600,0,32'h0,  0,32'h404,0,32'h404,32'h0);
    add(0,0,0,1,32'hAA,       1,32'h600,1,32'h604,32'hAA);

    // Reset state
    #2;
    check("reset_req", 32'(imem_req), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_pc", pc, 32'h0);
    check("reset_instr", instruction, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    @(negedge clk); rst = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].frz, vecs[i].br, vecs[i].baddr, vecs[i].rdy, vecs[i].rdata);
      #1;
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_instr", i), instruction, vecs[i].e_instr);
    end

    // Reset in the middle of S_WAIT acts without a clock edge
    @(negedge clk); drive(0, 0, '0, 0, '0);
    @(posedge clk); #1;
    check("rstwait_req_before", 32'(imem_req), 32'h1);
    @(negedge clk); rst = 1; #1;
    check("rstwait_req", 32'(imem_req), 32'h0);
    check("rstwait_valid", 32'(valid), 32'h0);
    check("rstwait_pc", pc, 32'h0);
    check("rstwait_instr", instruction, 32'h0);
    @(negedge clk); rst = 0; drive(0, 0, '0, 1, 32'hCAFE_F00D); #1;
    check("rstwait_addr_after", imem_addr, 32'h0);
    check("rstwait_req_after", 32'(imem_req), 32'h1);
    @(posedge clk); #1;
    check("rstwait_first_pc", pc, 32'h4);
    check("rstwait_first_instr", instruction, 32'hCAFE_F00D);

    // Address wrap
    @(negedge clk); w_rst = 0; #1;
    check("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_valid", 32'(w_valid), 32'h1);
    check("wrap_addr1", w_imem_addr, 32'h0);

    // Randomized traffic against the model
    @(negedge clk); rst = 1; drive(0, 0, '0, 0, '0);
    @(negedge clk); rst = 0; model_reset(32'h0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r_frz   = ($urandom_range(0, 3) == 0);
      r_br    = ($urandom_range(0, 7) == 0);
      r_baddr = $urandom;
      r_rdy   = ($urandom_range(0, 2) != 0);
      r_rdata = $urandom;
      drive(r_frz, r_br, r_baddr, r_rdy, r_rdata);
      #1;
      check($sformatf("rnd%0d_req", i), 32'(imem_req), 32'(model_req(r_frz)));
      check($sformatf("rnd%0d_addr", i), imem_addr, m_fetch);
      @(posedge clk);
      model_edge(r_frz, r_br, r_baddr, r_rdy, r_rdata);
      #1;
      check($sformatf("rnd%0d_valid", i), 32'(valid), 32'(m_valid));
      check($sformatf("rnd%0d_pc", i), pc, m_pc);
      check($sformatf("rnd%0d_instr", i), instruction, m_instr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
